// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: Start/Ack run handshake, write-enable gating,
// load stall for the data-memory read latency, and per-run cycle/retire counters.
module ctrl_seq #(
   parameter int         IW      = 9,
   parameter int         MEM_LAT = 2,
   parameter logic [4:0] LD_OP   = 5'b01000,
   parameter int         CW      = 16
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [IW-1:0] Instruction,
   input  logic          RegWrReq,
   input  logic          MemWrReq,
   output logic          InitPc,
   output logic          FetchEn,
   output logic          RegWrEn,
   output logic          MemWrEn,
   output logic          MemRdEn,
   output logic          Busy,
   output logic          Ack,
   output logic [CW-1:0] CycleCount,
   output logic [CW-1:0] InstrCount
);

   typedef enum logic [1:0] {IDLE, EXEC, MEMRD, HALT} state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t     state, next_state;
   logic [3:0] wait_cnt, wait_nxt;
   logic       halt, load;
   logic       clr_cnt, cyc_inc, ins_inc;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign halt = &Instruction;
   assign load = (Instruction[IW-1:IW-5] == LD_OP) && !halt;

   always_comb begin
      next_state = state;
      wait_nxt   = wait_cnt;
      clr_cnt    = 1'b0;
      cyc_inc    = 1'b0;
      ins_inc    = 1'b0;
      InitPc     = 1'b0;
      FetchEn    = 1'b0;
      RegWrEn    = 1'b0;
      MemWrEn    = 1'b0;
      MemRdEn    = 1'b0;
      Busy       = 1'b0;
      Ack        = 1'b0;
      case (state)
         IDLE: begin
            InitPc = Start;
            if (Start) begin
               next_state = EXEC;
               clr_cnt    = 1'b1;
            end
         end
         EXEC: begin
            Busy = 1'b1;
            if (Start) begin
               // abort: restart the program with every strobe suppressed
               InitPc     = 1'b1;
               clr_cnt    = 1'b1;
               wait_nxt   = '0;
               next_state = EXEC;
            end else begin
               cyc_inc = 1'b1;
               if (halt) begin
                  next_state = HALT;
               end else if (load) begin
                  MemRdEn    = 1'b1;
                  wait_nxt   = LAT_M1;
                  next_state = MEMRD;
               end else begin
                  FetchEn = 1'b1;
                  RegWrEn = RegWrReq;
                  MemWrEn = MemWrReq;
                  ins_inc = 1'b1;
               end
            end
         end
         MEMRD: begin
            Busy = 1'b1;
            if (Start) begin
               InitPc     = 1'b1;
               clr_cnt    = 1'b1;
               wait_nxt   = '0;
               next_state = EXEC;
            end else begin
               cyc_inc = 1'b1;
               if (wait_cnt != '0) begin
                  wait_nxt = wait_cnt - 1'b1;
               end else begin
                  // final cycle of the load: read data valid, write it back
                  RegWrEn    = RegWrReq;
                  FetchEn    = 1'b1;
                  ins_inc    = 1'b1;
                  next_state = EXEC;
               end
            end
         end
         HALT: begin
            Ack = 1'b1;
            if (Start) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      if (Reset) begin
         InitPc  = 1'b0;
         FetchEn = 1'b0;
         RegWrEn = 1'b0;
         MemWrEn = 1'b0;
         MemRdEn = 1'b0;
         Busy    = 1'b0;
         Ack     = 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         CycleCount <= '0;
         InstrCount <= '0;
      end else begin
         state    <= next_state;
         wait_cnt <= wait_nxt;
         if (clr_cnt) begin
            CycleCount <= '0;
            InstrCount <= '0;
         end else begin
            if (cyc_inc) CycleCount <= sat_inc(CycleCount);
            if (ins_inc) InstrCount <= sat_inc(InstrCount);
         end
      end
   end

   a_ack_busy: assert property (@(posedge Clk) disable iff (Reset) !(Ack && Busy));
   a_rd_wr:    assert property (@(posedge Clk) disable iff (Reset) !(MemRdEn && (MemWrEn || RegWrEn)));

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
Multi-cycle control sequencer that sits beside the combinational Ctrl decoder and generalises single-cycle control into a parametrised sequenced controller. It owns the Start/Ack run handshake. It gates the decoder's write requests so they fire only in the correct cycle, and it stalls fetch for a configurable data-memory read latency. It also keeps run-time cycle and retired-instruction counters for the bench.

Parameters:
IW, 9, instruction width in bits
MEM_LAT, 2, data_mem read latency in cycles (legal 1..15)
LD_OP, 5'b01000, value of Instruction[IW-1:IW-5] identifying a load
CW, 16, width of CycleCount and InstrCount

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  run request from testbench/top_level
Instruction  in  IW  current word from instruction ROM
RegWrReq  in  1  RegWrEn from Ctrl decoder (ungated)
MemWrReq  in  1  MemWrEn from Ctrl decoder (ungated)
InitPc  out  1  PC load-to-zero strobe
FetchEn  out  1  PC advance/jump enable
RegWrEn  out  1  gated reg_file write enable
MemWrEn  out  1  gated data_mem write enable
MemRdEn  out  1  data_mem read strobe
Busy  out  1  program executing
Ack  out  1  program done, held
CycleCount  out  CW  cycles spent in EXEC+MEMRD this run
InstrCount  out  CW  instructions retired this run

Behaviour:
- Reset is asynchronous and active-high. Clk is the single clock.
- While Reset is high: state=IDLE, wait counter=0, CycleCount=0, InstrCount=0. Every output is 0.
- States: IDLE, EXEC, MEMRD, HALT. State is registered; outputs are decoded from state plus the current Instruction/Req inputs.
- Derived signals:
  - halt = &Instruction.
  - load = (Instruction[IW-1:IW-5]==LD_OP) and not halt.
- IDLE:
  - InitPc=Start. All other outputs are 0.
  - Start=1 -> next state EXEC, and both counters clear.
- EXEC (Busy=1):
  - CycleCount increments by 1 per cycle and saturates at all-ones.
  - halt: FetchEn=0, RegWrEn=0, MemWrEn=0. Next state HALT. Not counted as retired.
  - load: MemRdEn=1, FetchEn=0, RegWrEn=0. Wait counter is loaded with MEM_LAT-1. Next state MEMRD.
  - Otherwise: FetchEn=1, RegWrEn=RegWrReq, MemWrEn=MemWrReq. InstrCount increments by 1 (saturating). Stay in EXEC.
- MEMRD (Busy=1; CycleCount increments):
  - MemRdEn=0, MemWrEn=0. Instruction is held stable by the stalled PC.
  - Wait counter > 0: decrement it; FetchEn=0, RegWrEn=0.
  - Wait counter = 0: RegWrEn=RegWrReq, FetchEn=1, InstrCount increments. Next state EXEC.
  - A load therefore occupies 1+MEM_LAT cycles, and its writeback happens in the final cycle.
- HALT:
  - Ack=1, Busy=0. All strobes are 0. Counters hold for readout.
  - Start=1 -> next state IDLE, and Ack drops on the following cycle.
- Start in EXEC or MEMRD is an abort:
  - No strobes are asserted that cycle (InitPc=1, FetchEn=0, RegWrEn=0, MemWrEn=0, MemRdEn=0).
  - Next state EXEC with both counters cleared, i.e. an immediate restart.
- Reset asserted mid-load abandons the read. No writeback occurs.
- MemWrEn and RegWrEn are never asserted in the same cycle as MemRdEn.
- Ack and Busy are never both 1.

Test Plan:
- Reset, then Start pulse for 1 cycle with a program of 3 ALU ops and then Instruction=9'h1FF.
  - InitPc=1 for exactly that cycle.
  - RegWrEn follows RegWrReq for 3 cycles.
  - Ack=1 from the 5th cycle after Start, and held.
  - CycleCount=4, InstrCount=3.
- Load (Instruction=9'b01000_0100, RegWrReq=1) with MEM_LAT=2.
  - MemRdEn=1 for cycle 1 only.
  - FetchEn=0 for cycles 1-2, then 1 in cycle 3.
  - RegWrEn=1 in cycle 3 only.
  - InstrCount increments by 1.
- Rerun with MEM_LAT=1 and MEM_LAT=4: the load spans 2 cycles and 5 cycles respectively.
- Store (MemWrReq=1) -> MemWrEn=1 for one cycle, RegWrEn=0, FetchEn=1.
- Start asserted in the second MEMRD cycle -> no RegWrEn. Next cycle state EXEC, CycleCount=0. Program reruns identically.
- Reset asserted asynchronously mid-run (between edges) -> all outputs drop to 0 immediately. With Ack high, Start -> Ack=0 one cycle later, and the following Start begins a fresh run.
